// File: rtl/register_file_rt.sv
// Multi-ported renaming register file: data, ROB tag and filled scoreboard per register.
// Optional REGFILE_COMMIT_BYPASS_EN forwards same-cycle matching commits to the read ports.
module register_file_rt #(
    parameter int unsigned N_RD_PORTS  = 3,
    parameter int unsigned N_RSV_PORTS = 1,
    parameter int unsigned N_WR_PORTS  = 1,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned RSV_ID_W    = 4,
    parameter bit          ZERO_REG    = 1'b1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     branch_miss,
    input  logic [N_RSV_PORTS-1:0]                   rsv,
    input  logic [N_RSV_PORTS*REG_ADDR_W-1:0]        rsv_addr,
    input  logic [N_RSV_PORTS*RSV_ID_W-1:0]          rsv_id,
    input  logic [N_WR_PORTS-1:0]                    we,
    input  logic [N_WR_PORTS*RSV_ID_W-1:0]           wr_que_addr,
    input  logic [N_WR_PORTS*REG_ADDR_W-1:0]         wr_addr,
    input  logic [N_WR_PORTS*DATA_W-1:0]             wr_data,
    input  logic [N_RD_PORTS*REG_ADDR_W-1:0]         rd_addrs,
    output logic [N_RD_PORTS*(DATA_W+RSV_ID_W)-1:0]  rd_data,
    output logic [N_RD_PORTS-1:0]                    rd_data_filled,
    output logic [REG_ADDR_W:0]                      busy_cnt
);

    localparam int unsigned N_REGS  = 1 << REG_ADDR_W;
    localparam int unsigned ENTRY_W = DATA_W + RSV_ID_W;
    localparam int unsigned CNT_W   = REG_ADDR_W + 1;

    logic [DATA_W-1:0]   data_q   [N_REGS];
    logic [DATA_W-1:0]   data_d   [N_REGS];
    logic [RSV_ID_W-1:0] tag_q    [N_REGS];
    logic [RSV_ID_W-1:0] tag_d    [N_REGS];
    logic                filled_q [N_REGS];
    logic                filled_d [N_REGS];
    logic [CNT_W-1:0]    busy_q;
    logic [CNT_W-1:0]    busy_d;

    // Next state: commits first, then flush or reserves override tag/filled.
    always_comb begin
        logic [REG_ADDR_W-1:0] wa;
        logic [REG_ADDR_W-1:0] ra;
        data_d   = data_q;
        tag_d    = tag_q;
        filled_d = filled_q;
        busy_d   = '0;
        wa       = '0;
        ra       = '0;
        for (int w = 0; w < int'(N_WR_PORTS); w++) begin
            wa = wr_addr[w*REG_ADDR_W +: REG_ADDR_W];
            if (we[w] && !(ZERO_REG && wa == '0)) begin
                data_d[wa] = wr_data[w*DATA_W +: DATA_W];
                if (tag_q[wa] == wr_que_addr[w*RSV_ID_W +: RSV_ID_W]) begin
                    filled_d[wa] = 1'b1;
                end
            end
        end
        if (branch_miss) begin
            for (int i = 0; i < int'(N_REGS); i++) begin
                tag_d[i]    = '0;
                filled_d[i] = 1'b1;
            end
        end else begin
            for (int r = 0; r < int'(N_RSV_PORTS); r++) begin
                ra = rsv_addr[r*REG_ADDR_W +: REG_ADDR_W];
                if (rsv[r] && !(ZERO_REG && ra == '0)) begin
                    tag_d[ra]    = rsv_id[r*RSV_ID_W +: RSV_ID_W];
                    filled_d[ra] = 1'b0;
                end
            end
        end
        for (int i = 0; i < int'(N_REGS); i++) begin
            busy_d = busy_d + CNT_W'(!filled_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_REGS); i++) begin
                data_q[i]   <= '0;
                tag_q[i]    <= '0;
                filled_q[i] <= 1'b1;
            end
            busy_q <= '0;
        end else begin
            data_q   <= data_d;
            tag_q    <= tag_d;
            filled_q <= filled_d;
            busy_q   <= busy_d;
        end
    end

    // Read ports: registered state, optionally overlaid with matching same-cycle commits.
    always_comb begin
        logic [REG_ADDR_W-1:0] a;
        logic [DATA_W-1:0]     rdat;
        logic [RSV_ID_W-1:0]   rtag;
        logic                  rfill;
        rd_data        = '0;
        rd_data_filled = '0;
        a              = '0;
        rdat           = '0;
        rtag           = '0;
        rfill          = 1'b1;
        for (int p = 0; p < int'(N_RD_PORTS); p++) begin
            a     = rd_addrs[p*REG_ADDR_W +: REG_ADDR_W];
            rdat  = data_q[a];
            rtag  = tag_q[a];
            rfill = filled_q[a];
`ifdef REGFILE_COMMIT_BYPASS_EN
            for (int w = 0; w < int'(N_WR_PORTS); w++) begin
                if (we[w] && wr_addr[w*REG_ADDR_W +: REG_ADDR_W] == a &&
                    tag_q[a] == wr_que_addr[w*RSV_ID_W +: RSV_ID_W]) begin
                    rdat  = wr_data[w*DATA_W +: DATA_W];
                    rfill = 1'b1;
                end
            end
`endif
            if (ZERO_REG && a == '0) begin
                rdat  = '0;
                rtag  = '0;
                rfill = 1'b1;
            end
            rd_data[p*ENTRY_W +: ENTRY_W] = {rtag, rdat};
            rd_data_filled[p]             = rfill;
        end
    end

    assign busy_cnt = busy_q;

endmodule

// File: doc/register_file_rt.md
Name: register_file_rt

Overview:
- Multi-ported architectural register file with a per-register rename tag and a "filled" scoreboard bit.
- Sits between decode/issue and the ROB. Issue reads operands and learns whether each one is ready or pending on a ROB tag. Issue reserves destination registers. The ROB commits results back.
- Generalises the single-reserve, single-commit register file to N read ports, N reserve ports and N commit ports, with defined intra-cycle priority.
- Adds a correct branch flush (tags and scoreboard both cleared), an optional hard-wired zero register and a pending-register counter.

Parameters:
- N_RD_PORTS, 3, number of combinational read ports
- N_RSV_PORTS, 1, number of reserve (destination rename) ports; higher index = younger in program order
- N_WR_PORTS, 1, number of ROB commit ports; higher index = younger
- DATA_W, 32, register data width
- REG_ADDR_W, 5, register address width; 2**REG_ADDR_W registers
- RSV_ID_W, 4, ROB tag width
- ZERO_REG, 1, 1 = register 0 reads 0, is never reserved and is never written

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- branch_miss  in  1  flush all pending renames
- rsv  in  N_RSV_PORTS  reserve valid per port
- rsv_addr  in  N_RSV_PORTS*REG_ADDR_W  destination register per reserve port
- rsv_id  in  N_RSV_PORTS*RSV_ID_W  ROB tag per reserve port
- we  in  N_WR_PORTS  commit valid per port
- wr_que_addr  in  N_WR_PORTS*RSV_ID_W  ROB tag of committing entry
- wr_addr  in  N_WR_PORTS*REG_ADDR_W  committing register
- wr_data  in  N_WR_PORTS*DATA_W  committed value
- rd_addrs  in  N_RD_PORTS*REG_ADDR_W  read addresses
- rd_data  out  N_RD_PORTS*(DATA_W+RSV_ID_W)  {tag, data} per read port
- rd_data_filled  out  N_RD_PORTS  1 = data valid, 0 = wait for tag
- busy_cnt  out  REG_ADDR_W+1  number of registers with filled=0

Behaviour:
- State per register: data[DATA_W], tag[RSV_ID_W], filled[1].
- Async reset: data=0, tag=0, filled=1, busy_cnt=0. Outputs reflect this immediately on reset assertion.
- Reads:
  - Combinational, zero latency, from the current registered state.
  - rd_data = {tag[a], data[a]}, rd_data_filled = filled[a].
  - With ZERO_REG=1, address 0 returns data 0, tag 0, filled 1.
- Commit (per port w with we[w]=1):
  - data[wr_addr] <= wr_data unconditionally.
  - filled[wr_addr] <= 1 only if tag[wr_addr] == wr_que_addr, with tag compared pre-edge. A stale commit updates data but not the scoreboard.
  - Multiple commits to the same register in one cycle: highest port index wins for data. filled is set if any matching commit exists.
- Reserve (per port r with rsv[r]=1, unless ZERO_REG=1 and rsv_addr=0, which is ignored):
  - tag[rsv_addr] <= rsv_id, filled[rsv_addr] <= 0.
  - Multiple reserves to the same register: highest port index wins.
- Reserve and commit to the same register in the same cycle: reserve wins for tag and filled; the commit data is still written.
- branch_miss=1:
  - Next edge sets all tag=0 and filled=1.
  - Same-cycle reserves are discarded.
  - Same-cycle commits still write data.
- busy_cnt:
  - Registered popcount of ~filled, updated on the same edge as the state.
  - 0 after flush or reset.
  - Never exceeds 2**REG_ADDR_W (or 2**REG_ADDR_W-1 with ZERO_REG=1).
- Tag wrap-around: the block does no tag age tracking; only equality compares. The ROB guarantees no live-tag aliasing.

Optional Feature:
- Macro: REGFILE_COMMIT_BYPASS_EN.
- Defined: a read whose address matches a same-cycle commit with a matching tag returns wr_data with filled=1 combinationally; highest commit port wins. A same-cycle reserve to that address does not affect the read, which sees pre-edge state plus bypass.
- Undefined: reads see registered state only; the commit result is visible on the next cycle.

Test Plan:
- Reset then read r1..r3 -> data 0, tag 0, filled 1, busy_cnt=0. Assert rst mid-run with r5 pending -> r5 filled=1 immediately.
- Reserve r5 with tag 3; commit r5, tag 3, 0xDEADBEEF next cycle -> cycle+1 r5 filled=0, tag 3; cycle+2 data 0xDEADBEEF, filled=1, busy_cnt 1->0.
- Reserve r7 with tag 2, then tag 4; commit r7 with tag 2 value 0x11 -> data 0x11, filled stays 0, tag 4, busy_cnt=1.
- Reserve r4 with tag 1 while committing r4 with tag 0 (it held tag 0 and filled=0) value 0x22 in the same cycle -> data 0x22, tag 1, filled=0.
- Reserve r1, r2, r3; assert branch_miss together with a reserve of r6 and a commit of r8=0x55 -> all filled=1, all tags 0, r6 not reserved, r8=0x55, busy_cnt=0.
- ZERO_REG=1: reserve r0 and commit r0=0xFF -> r0 reads 0, filled=1. With REGFILE_COMMIT_BYPASS_EN, commit r9 with a matching tag -> read r9 shows the new value in the same cycle.
